// File: rtl/fibonacci_engine.sv
// Iterative Fibonacci/Lucas term generator with a begin/busy/done handshake,
// abort, and sticky overflow detection with optional saturation.
module fibonacci_engine #(
    parameter int WIDTH    = 16,
    parameter int N_WIDTH  = 5,
    parameter int SATURATE = 0
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               begin_fibo,
    input  logic [N_WIDTH-1:0] input_s,
    input  logic               mode,
    input  logic               abort,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   fibo_out,
    output logic               overflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] SEED_A_FIB = '0;
    localparam logic [WIDTH-1:0] SEED_A_LUC = WIDTH'(2);
    localparam logic [WIDTH-1:0] SEED_B     = WIDTH'(1);

    state_t             state;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic [N_WIDTH-1:0] cnt;
    logic               ovf_a;
    logic               ovf_b;
    logic [WIDTH:0]     sum;
    logic               carry;
    logic               load;
    logic               step;
    logic               finish;

    function automatic logic [WIDTH-1:0] saturate_result(input logic [WIDTH-1:0] val,
                                                         input logic ovf);
        logic [WIDTH-1:0] res;
        res = val;
        if ((SATURATE != 0) && ovf) begin
            res = '1;
        end
        return res;
    endfunction

    assign sum    = {1'b0, a} + {1'b0, b};
    assign carry  = sum[WIDTH];
    assign load   = ((state == IDLE) || (state == DONE)) && begin_fibo;
    assign step   = (state == CALC) && !abort && (cnt != '0);
    assign finish = (state == CALC) && !abort && (cnt == '0);

    // Datapath: seeds on an accepted start, one term per CALC step.
    // ovf_b folds in both flags so an overflow anywhere earlier stays sticky.
    always_ff @(posedge clk) begin
        if (load) begin
            cnt   <= input_s;
            a     <= mode ? SEED_A_LUC : SEED_A_FIB;
            b     <= SEED_B;
            ovf_a <= 1'b0;
            ovf_b <= 1'b0;
        end else if (step) begin
            a     <= b;
            b     <= sum[WIDTH-1:0];
            ovf_a <= ovf_b;
            ovf_b <= carry | ovf_a | ovf_b;
            cnt   <= cnt - 1'b1;
        end
    end

    // Control and result registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            fibo_out <= '0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (load) begin
                        state <= CALC;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                    end
                end
                CALC: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                    end else if (finish) begin
                        fibo_out <= saturate_result(a, ovf_a);
                        overflow <= ovf_a;
                        state    <= DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fibonacci_engine.sv
// Scoreboard bench: wrapping and saturating instances share stimulus; a monitor
// pops the expected result on each rising edge of done.
module tb_fibonacci_engine;

    logic        clk;
    logic        reset_n;
    logic        begin_fibo;
    logic [4:0]  input_s;
    logic        mode;
    logic        abort;
    logic        busy_w, done_w, ovf_w;
    logic        busy_s, done_s, ovf_s;
    logic [15:0] fibo_w, fibo_s;

    typedef struct {
        int unsigned fib_wrap;
        int unsigned fib_sat;
        bit          ovf;
        int unsigned cyc;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          total  = 0;
    int          passed = 0;
    int unsigned cyc    = 0;
    logic        done_prev = 1'b0;

    fibonacci_engine #(.WIDTH(16), .N_WIDTH(5), .SATURATE(0)) dut_wrap (
        .clk(clk), .reset_n(reset_n), .begin_fibo(begin_fibo), .input_s(input_s),
        .mode(mode), .abort(abort), .busy(busy_w), .done(done_w),
        .fibo_out(fibo_w), .overflow(ovf_w)
    );

    fibonacci_engine #(.WIDTH(16), .N_WIDTH(5), .SATURATE(1)) dut_sat (
        .clk(clk), .reset_n(reset_n), .begin_fibo(begin_fibo), .input_s(input_s),
        .mode(mode), .abort(abort), .busy(busy_s), .done(done_s),
        .fibo_out(fibo_s), .overflow(ovf_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input bit ok, input string nm, input longint act, input longint req);
        total++;
        if (ok) passed++;
        else $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    endtask

    // Monitor
    always @(negedge clk) begin
        if (done_w && !done_prev) begin
            if (sb.size() == 0) begin
                check(1'b0, "unexpected_done", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check(fibo_w == mon_e.fib_wrap[15:0], "wrap_result", fibo_w, mon_e.fib_wrap);
                check(ovf_w == mon_e.ovf, "wrap_overflow", ovf_w, mon_e.ovf);
                check(fibo_s == mon_e.fib_sat[15:0], "sat_result", fibo_s, mon_e.fib_sat);
                check(ovf_s == mon_e.ovf, "sat_overflow", ovf_s, mon_e.ovf);
                check(done_s == 1'b1, "sat_done", done_s, 1);
                check(cyc == mon_e.cyc, "done_latency", cyc, mon_e.cyc);
            end
        end
        done_prev = done_w;
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic start(input int n, input bit m, input bit push,
                         input int unsigned fw, input int unsigned fs, input bit ov,
                         input bit with_abort);
        exp_t e;
        input_s    = 5'(n);
        mode       = m;
        begin_fibo = 1'b1;
        abort      = with_abort;
        if (push) begin
            e.fib_wrap = fw;
            e.fib_sat  = fs;
            e.ovf      = ov;
            e.cyc      = cyc + 32'(n) + 2;
            sb.push_back(e);
        end
        @(negedge clk);
        begin_fibo = 1'b0;
        abort      = 1'b0;
    endtask

    task automatic wait_done(input int busy_exp, input string nm);
        int bc = 0;
        for (int i = 0; i < 200; i++) begin
            if (done_w) break;
            if (busy_w) bc++;
            @(negedge clk);
        end
        if (!done_w) begin
            check(1'b0, {nm, "_timeout"}, 0, 1);
        end else begin
            check(bc == busy_exp, {nm, "_busy_cycles"}, bc, busy_exp);
        end
    endtask

    task automatic run(input int n, input bit m, input int unsigned fw,
                       input int unsigned fs, input bit ov, input string nm);
        start(n, m, 1'b1, fw, fs, ov, 1'b0);
        wait_done(n + 1, nm);
    endtask

    initial begin
        reset_n    = 1'b0;
        begin_fibo = 1'b0;
        input_s    = '0;
        mode       = 1'b0;
        abort      = 1'b0;
        repeat (2) @(negedge clk);
        check(busy_w == 1'b0, "reset_busy", busy_w, 0);
        check(done_w == 1'b0, "reset_done", done_w, 0);
        check(fibo_w == 16'd0, "reset_fibo", fibo_w, 0);
        check(ovf_w == 1'b0, "reset_overflow", ovf_w, 0);
        check(fibo_s == 16'd0, "reset_fibo_sat", fibo_s, 0);
        reset_n = 1'b1;
        @(negedge clk);

        run(10, 1'b0, 55, 55, 1'b0, "fib10");
        repeat (3) @(negedge clk);
        check(done_w == 1'b1, "done_hold", done_w, 1);
        check(fibo_w == 16'd55, "done_hold_value", fibo_w, 55);

        // Back-to-back from DONE
        start(7, 1'b0, 1'b1, 13, 13, 1'b0, 1'b0);
        check(done_w == 1'b0, "b2b_done_drop", done_w, 0);
        check(fibo_w == 16'd55, "b2b_result_held", fibo_w, 55);
        wait_done(8, "fib7");

        run(0, 1'b0, 0, 0, 1'b0, "fib0");
        run(0, 1'b1, 2, 2, 1'b0, "luc0");
        run(5, 1'b1, 11, 11, 1'b0, "luc5");
        run(24, 1'b0, 46368, 46368, 1'b0, "fib24");
        run(25, 1'b0, 9489, 65535, 1'b1, "fib25");
        run(31, 1'b0, 35549, 65535, 1'b1, "fib31");
        run(31, 1'b1, 61229, 65535, 1'b1, "luc31");

        // Start ignored while busy
        start(20, 1'b0, 1'b1, 6765, 6765, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        input_s    = 5'd3;
        mode       = 1'b1;
        begin_fibo = 1'b1;
        @(negedge clk);
        begin_fibo = 1'b0;
        wait_done(17, "fib20_ignore");

        // Abort mid-run
        start(20, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check(busy_w == 1'b0, "abort_busy", busy_w, 0);
        check(done_w == 1'b0, "abort_done", done_w, 0);
        check(fibo_w == 16'd6765, "abort_fibo_kept", fibo_w, 6765);
        check(fibo_s == 16'd6765, "abort_fibo_sat_kept", fibo_s, 6765);

        // Abort wins over begin in CALC
        start(20, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        abort      = 1'b1;
        begin_fibo = 1'b1;
        input_s    = 5'd3;
        @(negedge clk);
        abort      = 1'b0;
        begin_fibo = 1'b0;
        check(busy_w == 1'b0, "abort_beats_begin", busy_w, 0);
        @(negedge clk);
        check(busy_w == 1'b0, "abort_stays_idle", busy_w, 0);

        // begin with abort in IDLE is accepted
        start(3, 1'b0, 1'b1, 2, 2, 1'b0, 1'b1);
        wait_done(4, "fib3_abort_idle");

        // Reset mid-CALC
        start(20, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check(busy_w == 1'b0, "midreset_busy", busy_w, 0);
        check(done_w == 1'b0, "midreset_done", done_w, 0);
        check(fibo_w == 16'd0, "midreset_fibo", fibo_w, 0);
        check(ovf_w == 1'b0, "midreset_overflow", ovf_w, 0);
        check(fibo_s == 16'd0, "midreset_fibo_sat", fibo_s, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        run(5, 1'b1, 11, 11, 1'b0, "luc5_after_reset");

        repeat (3) @(negedge clk);
        check(sb.size() == 0, "scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fibonacci_engine.md
Name: fibonacci_engine

Overview:
Parametrised, multi-sequence successor to the single-width Fibonacci calculator. It computes the n-th term of either the Fibonacci sequence (seeds 0,1) or the Lucas sequence (seeds 2,1), using an iterative add-and-shift datapath and a clean begin/busy/done handshake. It adds an abort input and overflow detection with an optional saturating result. It is a standalone compute block driven by a controller that issues one request at a time.

Parameters:
WIDTH, 16, bit width of the datapath and the result.
N_WIDTH, 5, bit width of the requested index input_s; the maximum index is 2^N_WIDTH-1.
SATURATE, 0, 0 = the result wraps modulo 2^WIDTH on overflow; 1 = the result is forced to all-ones on overflow.

Ports:
clk  input  1  single clock; all state changes on the rising edge.
reset_n  input  1  asynchronous active-low reset.
begin_fibo  input  1  start request; sampled only when busy=0.
input_s  input  N_WIDTH  requested index n; latched on an accepted start.
mode  input  1  0 = Fibonacci, 1 = Lucas; latched on an accepted start.
abort  input  1  synchronous cancel of a running computation.
busy  output  1  high while a computation is in progress.
done  output  1  high while a valid result is held.
fibo_out  output  WIDTH  result register.
overflow  output  1  the true result exceeded 2^WIDTH-1; qualified by done.

Behaviour:
- Reset value of every output is 0 (busy, done, fibo_out, overflow). The FSM resets to IDLE. Reset asserted mid-operation discards the run immediately.
- FSM states: IDLE, CALC, DONE.
- Start acceptance: when the state is IDLE or DONE and begin_fibo=1, the start is accepted:
  - latch cnt<=input_s;
  - load seeds: a<=0, b<=1 (mode 0); a<=2, b<=1 (mode 1);
  - clear the internal overflow flags ovf_a and ovf_b;
  - go to CALC, with busy=1 and done=0 from the next cycle.
  - fibo_out holds its previous value until the new result is written.
- CALC step, when cnt!=0 and abort=0:
  - a<=b; b<=a+b computed at WIDTH+1 bits and truncated to WIDTH;
  - ovf_a<=ovf_b; ovf_b<=carry|ovf_a|ovf_b;
  - cnt<=cnt-1.
- CALC exit, when cnt==0 and abort=0:
  - fibo_out<=a, or all-ones if SATURATE=1 and ovf_a=1;
  - overflow<=ovf_a;
  - go to DONE with done=1, busy=0.
- Latency: done rises on the (n+1)-th rising edge after the edge that accepted the start. n=0 gives 1 cycle.
- DONE holds fibo_out, overflow and done=1 indefinitely. A new accepted start in DONE clears done on the next edge (back-to-back operation, no IDLE visit required).
- begin_fibo while busy=1 is ignored; input_s and mode changes during CALC have no effect.
- abort=1 in CALC: go to IDLE on the next edge with busy=0 and done=0; fibo_out and overflow keep their previous values. abort is ignored in IDLE and DONE.
- abort and begin_fibo together in CALC: abort wins and begin is ignored.
- In IDLE and DONE, begin_fibo=1 together with abort=1: the start is accepted.
- Wrap mode: fibo_out = term(n) mod 2^WIDTH, which stays exact because modular addition is consistent.
- Overflow is sticky per run: once any term at or before position n has overflowed, every later term is flagged.
- Index range: the maximum input_s of 2^N_WIDTH-1 needs no special case; the counter never wraps.

Test Plan:
- Reset, then mode=0, input_s=10, one-cycle begin_fibo -> busy high for 11 cycles; done rises on the 11th edge with fibo_out=55, overflow=0. done holds until the next start.
- input_s=0, mode=0 -> done after 1 cycle, fibo_out=0. Repeat with mode=1 -> fibo_out=2. Lucas with input_s=5 -> fibo_out=11.
- WIDTH=16, input_s=24 -> fibo_out=46368, overflow=0. input_s=25 with SATURATE=0 -> fibo_out=9489, overflow=1. Same run with SATURATE=1 -> fibo_out=65535, overflow=1.
- Start input_s=20, then pulse begin_fibo with input_s=3 during CALC -> the second request is ignored; result is 6765.
- Back-to-back: in DONE holding 55, start input_s=7 -> done drops on the next edge, then fibo_out=13 after 8 cycles.
- Abort 5 cycles into an input_s=20 run -> IDLE, busy=0, done=0, fibo_out retains the prior value. Separately, assert reset_n=0 mid-CALC -> all outputs 0 immediately; a new start then works normally.
